getwork_serial_rx: RTL and testbench

- UART receive stage in front of the miner core.
- Deserialises 8N1 bytes from RxD and assembles an 84-byte (672-bit) getwork frame.
- Presents the frame in parallel with a one-cycle rx_done strobe; the core latches data and nonce on that strobe.
- Guards against partial frames with an inter-byte timeout and stop-bit checking.

---
 rtl/ltcminer_pkg.sv | 7 +
 rtl/uart_rx_byte.sv | 76 +++++++
 rtl/getwork_serial_rx.sv | 90 +++++++++
 tb/tb_getwork_serial_rx.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/ltcminer_pkg.sv
// ltcminer_pkg: shared getwork frame geometry, PLL magic and UART receive FSM encoding
package ltcminer_pkg;
  localparam int FRAME_BYTES = 84;
  localparam int WORK_BITS = 8 * FRAME_BYTES;
  localparam logic [15:0] DYNPLL_MAGIC = 16'h55aa;
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} rx_state_t;
endpackage

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 8N1 byte receiver with 2-flop synchroniser and mid-bit sampling
module uart_rx_byte #(
  parameter int BIT_CYCLES = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_rx,
  output logic [7:0] o_byte,
  output logic       o_byte_valid,
  output logic       o_stop_err,
  output logic       o_start,
  output logic       o_idle
);
  import ltcminer_pkg::*;
  localparam int HALF = BIT_CYCLES / 2;
  localparam int CW = $clog2(BIT_CYCLES + 1);
  rx_state_t     r_state;
  logic [1:0]    r_sync;
  logic          r_prev;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic          w_rx;
  logic          w_fall;
  logic          w_tick;
  assign w_rx   = r_sync[1];
  assign w_fall = r_prev & ~w_rx;
  assign w_tick = r_cnt == CW'(1);
  assign o_idle = r_state == S_IDLE;
  // Counter loaded with N expires N cycles later; START confirm raises o_start
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_sync       <= 2'b11;
      r_prev       <= 1'b1;
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_bit        <= '0;
      r_shift      <= '0;
      o_byte       <= '0;
      o_byte_valid <= 1'b0;
      o_stop_err   <= 1'b0;
      o_start      <= 1'b0;
    end else begin
      r_sync       <= {r_sync[0], i_rx};
      r_prev       <= w_rx;
      o_byte_valid <= 1'b0;
      o_stop_err   <= 1'b0;
      o_start      <= 1'b0;
      if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
      case (r_state)
        S_IDLE: if (w_fall) begin
          r_state <= S_START;
          r_cnt   <= CW'(HALF);
        end
        S_START: if (w_tick) begin
          r_state <= w_rx ? S_IDLE : S_DATA;
          r_cnt   <= w_rx ? '0 : CW'(BIT_CYCLES);
          r_bit   <= '0;
          o_start <= ~w_rx;
        end
        S_DATA: if (w_tick) begin
          r_shift <= {w_rx, r_shift[7:1]};
          r_bit   <= r_bit + 3'd1;
          r_cnt   <= CW'(BIT_CYCLES);
          if (r_bit == 3'd7) r_state <= S_STOP;
        end
        S_STOP: if (w_tick) begin
          r_state      <= S_IDLE;
          o_byte_valid <= w_rx;
          o_stop_err   <= ~w_rx;
          if (w_rx) o_byte <= r_shift;
        end
        default: r_state <= S_IDLE;
      endcase
    end
endmodule

// File: rtl/getwork_serial_rx.sv
// getwork_serial_rx: assembles 8N1 serial bytes into a getwork frame with timeout abort.
// Define DYNPLL_DETECT_EN to decode 0x55AA-prefixed frames as PLL commands.
module getwork_serial_rx #(
  parameter int comm_clk_frequency = 100_000_000,
  parameter int baud_rate          = 115_200,
  parameter int FRAME_BYTES        = ltcminer_pkg::FRAME_BYTES,
  parameter int TIMEOUT_BITS       = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     RxD,
  output logic [8*FRAME_BYTES-1:0] data,
  output logic                     rx_done,
  output logic                     busy,
  output logic                     frame_err,
  output logic                     pll_req,
  output logic [15:0]              pll_value
);
  import ltcminer_pkg::*;
  localparam int BIT_CYCLES = comm_clk_frequency / baud_rate;
  localparam int DW = 8 * FRAME_BYTES;
  localparam int TO_CYCLES = TIMEOUT_BITS * BIT_CYCLES;
  localparam int TW = $clog2(TO_CYCLES + 1);
  localparam int NW = $clog2(FRAME_BYTES + 1);
  logic [7:0]    w_byte;
  logic          w_byte_valid;
  logic          w_stop_err;
  logic          w_start;
  logic          w_idle;
  logic          w_idle_run;
  logic          w_timeout;
  logic          w_last;
  logic [DW-1:0] w_next;
  logic [NW-1:0] r_count;
  logic [TW-1:0] r_idle_cnt;
  uart_rx_byte #(.BIT_CYCLES(BIT_CYCLES)) u_rx (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_rx         (RxD),
    .o_byte       (w_byte),
    .o_byte_valid (w_byte_valid),
    .o_stop_err   (w_stop_err),
    .o_start      (w_start),
    .o_idle       (w_idle)
  );
  assign w_idle_run = w_idle && r_count != '0;
  assign w_timeout  = w_idle_run && r_idle_cnt == TW'(TO_CYCLES - 1);
  assign w_last     = w_byte_valid && r_count == NW'(FRAME_BYTES - 1);
  assign w_next     = {data[DW-9:0], w_byte};
  // Timeout and stop errors discard the partial frame but leave data untouched
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      data       <= '0;
      rx_done    <= 1'b0;
      busy       <= 1'b0;
      frame_err  <= 1'b0;
      r_count    <= '0;
      r_idle_cnt <= '0;
    end else begin
      rx_done    <= 1'b0;
      frame_err  <= w_stop_err | w_timeout;
      r_idle_cnt <= (w_idle_run && !w_timeout) ? r_idle_cnt + 1'b1 : '0;
      if (w_timeout || w_stop_err) begin
        r_count <= '0;
        busy    <= 1'b0;
      end else if (w_byte_valid) begin
        data    <= w_next;
        r_count <= w_last ? '0 : r_count + 1'b1;
        busy    <= ~w_last;
        rx_done <= w_last;
      end else if (w_start) begin
        busy <= 1'b1;
      end
    end
`ifdef DYNPLL_DETECT_EN
  logic w_pll;
  assign w_pll = w_last && w_next[DW-1 -: 16] == DYNPLL_MAGIC;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pll_req   <= 1'b0;
      pll_value <= '0;
    end else begin
      pll_req <= w_pll;
      if (w_pll) pll_value <= w_next[DW-17 -: 16];
    end
`else
  assign pll_req   = 1'b0;
  assign pll_value = '0;
`endif
endmodule

// File: tb/tb_getwork_serial_rx.sv
// tb_getwork_serial_rx: randomized frame stimulus with a byte-queue reference model and event scoreboard
module tb_getwork_serial_rx;
  localparam int BC = 8;
  localparam int NB = 84;
  localparam int DW = 8 * NB;
  localparam int TO_BITS = 64;
`ifdef DYNPLL_DETECT_EN
  localparam bit PLL_EN = 1'b1;
`else
  localparam bit PLL_EN = 1'b0;
`endif
  logic          clk = 1'b0;
  logic          rst_n;
  logic          RxD;
  logic [DW-1:0] data;
  logic          rx_done;
  logic          busy;
  logic          frame_err;
  logic          pll_req;
  logic [15:0]   pll_value;
  getwork_serial_rx #(
    .comm_clk_frequency (1_000_000),
    .baud_rate          (115_200),
    .FRAME_BYTES        (NB),
    .TIMEOUT_BITS       (TO_BITS)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .RxD       (RxD),
    .data      (data),
    .rx_done   (rx_done),
    .busy      (busy),
    .frame_err (frame_err),
    .pll_req   (pll_req),
    .pll_value (pll_value)
  );
  always #5 clk = ~clk;

  typedef struct {
    bit            err;
    logic [DW-1:0] data;
    bit            pll;
    logic [15:0]   pv;
  } ev_t;
  ev_t        exp_q[$];
  logic [7:0] rxq[$];
  logic [7:0] fr[NB];
  logic [15:0] exp_pv = '0;
  int n_vec = 0;
  int n_err = 0;

  function automatic void check(string name, logic [DW-1:0] act, logic [DW-1:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endfunction

  function automatic void model_byte(logic [7:0] b);
    ev_t e;
    rxq.push_back(b);
    if (rxq.size() == NB) begin
      e.err  = 1'b0;
      e.data = '0;
      foreach (rxq[i]) e.data[DW-1-8*i -: 8] = rxq[i];
      e.pll  = PLL_EN && rxq[0] == 8'h55 && rxq[1] == 8'haa;
      e.pv   = {rxq[2], rxq[3]};
      exp_q.push_back(e);
      rxq.delete();
    end
  endfunction

  function automatic void model_abort();
    ev_t e;
    e.err  = 1'b1;
    e.data = '0;
    e.pll  = 1'b0;
    e.pv   = '0;
    exp_q.push_back(e);
    rxq.delete();
  endfunction

  task automatic send_byte(logic [7:0] b, bit stop_ok);
    if (stop_ok) model_byte(b);
    else model_abort();
    RxD = 1'b0;
    repeat (BC) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      RxD = b[i];
      repeat (BC) @(negedge clk);
    end
    RxD = stop_ok;
    repeat (BC) @(negedge clk);
    RxD = 1'b1;
  endtask

  task automatic send_frame();
    for (int i = 0; i < NB; i++) send_byte(fr[i], 1'b1);
  endtask

  task automatic rand_frame();
    for (int i = 0; i < NB; i++) fr[i] = 8'($urandom);
  endtask

  task automatic idle(int bits);
    repeat (bits * BC) @(negedge clk);
  endtask

  task automatic check_all_zero(string tag);
    check({tag, "_data"}, data, '0);
    check({tag, "_rx_done"}, rx_done, '0);
    check({tag, "_busy"}, busy, '0);
    check({tag, "_frame_err"}, frame_err, '0);
    check({tag, "_pll_req"}, pll_req, '0);
    check({tag, "_pll_value"}, pll_value, '0);
  endtask

  always @(negedge clk) begin
    ev_t e;
    if (!rst_n) exp_pv = '0;
    else if (rx_done || frame_err) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_event: rx_done=%b frame_err=%b, none expected", rx_done, frame_err);
      end else begin
        e = exp_q.pop_front();
        check("ev_rx_done", rx_done, !e.err);
        check("ev_frame_err", frame_err, e.err);
        check("ev_busy", busy, '0);
        if (!e.err) check("ev_data", data, e.data);
        check("ev_pll_req", pll_req, e.pll);
        if (e.pll) exp_pv = e.pv;
        check("ev_pll_value", pll_value, exp_pv);
      end
    end else if (pll_req) begin
      n_vec++;
      n_err++;
      $display("FAIL pll_req_alone: pll_req=1 expected 0 outside rx_done");
    end
  end

  initial begin
    rst_n = 1'b0;
    RxD   = 1'b1;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    idle(2);
    // PLL-style frame
    rand_frame();
    {fr[0], fr[1], fr[2], fr[3], fr[4], fr[5], fr[6], fr[7]} = 64'h55aa07ff0000318e;
    {fr[80], fr[81], fr[82], fr[83]} = 32'h01000000;
    send_frame();
    idle(2);
    check("busy_after_frame", busy, '0);
    // normal work frame, then a back-to-back random frame
    rand_frame();
    {fr[0], fr[1], fr[2], fr[3]} = 32'h000007ff;
    send_frame();
    rand_frame();
    send_frame();
    idle(2);
    // timeout abort after 40 bytes
    rand_frame();
    for (int i = 0; i < 40; i++) send_byte(fr[i], 1'b1);
    model_abort();
    idle(60);
    check("busy_before_timeout", busy, 1'b1);
    idle(10);
    check("busy_after_timeout", busy, '0);
    rand_frame();
    send_frame();
    idle(2);
    // bad stop bit on byte 10
    rand_frame();
    for (int i = 0; i < 10; i++) send_byte(fr[i], 1'b1);
    send_byte(8'($urandom), 1'b0);
    idle(2);
    check("busy_after_stop_err", busy, '0);
    rand_frame();
    send_frame();
    idle(2);
    // start glitch
    RxD = 1'b0;
    repeat (2) @(negedge clk);
    RxD = 1'b1;
    idle(4);
    check("busy_after_glitch", busy, '0);
    rand_frame();
    send_frame();
    idle(2);
    // reset in the middle of byte 50
    rand_frame();
    for (int i = 0; i < 50; i++) send_byte(fr[i], 1'b1);
    check("busy_mid_frame", busy, 1'b1);
    RxD = 1'b0;
    repeat (3 * BC) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    rxq.delete();
    @(negedge clk);
    RxD = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(3);
    rand_frame();
    send_frame();
    // random frames with random gaps
    for (int k = 0; k < 3; k++) begin
      idle($urandom_range(0, 3));
      rand_frame();
      if (k == 1) {fr[0], fr[1]} = 16'h55aa;
      send_frame();
    end
    for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(negedge clk);
    check("queue_drained", exp_q.size(), '0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
